// File: rtl/pam_demap_pipe.sv
// pam_demap_pipe: two-stage PAM symbol demapper.
//   Stage 1 adds the rounding bias to channels 1..N-1 (channel 0 is DC and
//   is dropped). Stage 2 slices each biased sample against the PAM
//   thresholds into a B-bit level. Both stages use valid/ready handshaking.
//   Samples above the top decision region are counted in clip_cnt.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready/in_last, u[N*W]      input word, channel k at [k*W +: W]
//   out_valid/out_ready/out_last, y[B*(N-1)] decided symbols, slice p-1 holds
//                                            channel N-p
//   clip_cnt[16]    saturating count of clipped samples
// Build option: define PAM_GRAY_EN to emit Gray-coded levels instead of binary.

// Per-channel slicer: biased sample -> level/symbol plus clip flag.
module pam_demap_lane #(
  parameter int W    = 12,
  parameter int B    = 2,
  parameter int STEP = 16
) (
  input  logic [W:0]   a,
  output logic [B-1:0] sym,
  output logic         clip
);
  localparam int L      = 1 << B;
  // One full STEP above the top threshold.
  localparam int CLIP_T = STEP/2 + (L-1)*STEP;

  logic [B-1:0] lvl;
  int           av;

  always_comb begin
    av   = int'($signed(a));
    lvl  = '0;
    // Level = number of thresholds strictly exceeded; negatives land on 0.
    for (int i = 0; i < L-1; i++)
      if (av > STEP/2 + i*STEP) lvl = lvl + B'(1);
    clip = av > CLIP_T;
  end

`ifdef PAM_GRAY_EN
  assign sym = lvl ^ (lvl >> 1);
`else
  assign sym = lvl;
`endif
endmodule

module pam_demap_pipe #(
  parameter int M    = 8,
  parameter int N    = 16,
  parameter int LOGN = 4,
  parameter int B    = 2,
  parameter int STEP = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N*(M+LOGN)-1:0]   u,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [B*(N-1)-1:0]      y,
  output logic [15:0]             clip_cnt
);
  localparam int W = M + LOGN;
  localparam int C = N - 1;   // channels actually demapped

  logic                adv1, adv2;
  logic                s1v, s1last, s2v;
  logic [C-1:0][W:0]   a_in, s1a;
  logic [C-1:0][B-1:0] sym, ynext;
  logic [C-1:0]        clip;
  logic [16:0]         clip_sum;
  logic                unused_ch0;

  // Channel 0 carries DC/bias only.
  assign unused_ch0 = ^u[W-1:0];

  // Stage 2 frees when empty or draining; stage 1 frees when it can move on.
  assign adv2      = !s2v || out_ready;
  assign adv1      = !s1v || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2v;

  // Lane g handles channel g+1; output slice q holds channel N-1-q.
  for (genvar g = 0; g < C; g++) begin : g_lane
    assign a_in[g] = {u[(g+2)*W-1], u[(g+2)*W-1 -: W]} + (W+1)'(1 << (LOGN-1));
    pam_demap_lane #(.W(W), .B(B), .STEP(STEP)) u_lane (
      .a    (s1a[g]),
      .sym  (sym[g]),
      .clip (clip[g])
    );
    assign ynext[C-1-g] = sym[g];
  end

  // New count with one extra bit to detect saturation.
  always_comb begin
    clip_sum = {1'b0, clip_cnt};
    for (int j = 0; j < C; j++) clip_sum = clip_sum + 17'(clip[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1v      <= 1'b0;
      s1last   <= 1'b0;
      s1a      <= '0;
      s2v      <= 1'b0;
      out_last <= 1'b0;
      y        <= '0;
      clip_cnt <= '0;
    end else begin
      if (adv1) begin
        s1v    <= in_valid;
        s1last <= in_last;
        s1a    <= a_in;
      end
      if (adv2) begin
        s2v <= s1v;
        // Output and clip count only move when a real word enters stage 2.
        if (s1v) begin
          y        <= ynext;
          out_last <= s1last;
          clip_cnt <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_pam_demap_pipe.sv
module tb_pam_demap_pipe;
  localparam int M = 8, N = 16, LOGN = 4, B = 2, STEP = 16;
  localparam int W = M + LOGN;
  localparam int L = 1 << B;
  localparam int YW = B*(N-1);

  logic            clk = 0, rst = 1;
  logic            in_valid = 0, in_last = 0, out_ready = 1;
  logic [N*W-1:0]  u = '0;
  logic            in_ready, out_valid, out_last;
  logic [YW-1:0]   y;
  logic [15:0]     clip_cnt;

  pam_demap_pipe #(.M(M), .N(N), .LOGN(LOGN), .B(B), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .u(u), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .y(y), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit rand_rdy = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decide each channel straight from the level definitions.
  typedef struct { logic [YW-1:0] y; logic last; logic [15:0] clip; } exp_t;
  exp_t q[$];
  int   cum = 0;

  function automatic void model(input logic [N*W-1:0] w, output logic [YW-1:0] ey,
                                output int nclip);
    ey = '0; nclip = 0;
    for (int p = 1; p < N; p++) begin
      logic [W-1:0] r;
      int s, a, lvl;
      r = w[(N-p)*W +: W];
      s = int'($signed(r));
      a = s + (1 << (LOGN-1));
      if (a <= STEP/2) lvl = 0;
      else begin
        lvl = (a - STEP/2 - 1) / STEP + 1;
        if (lvl > L-1) lvl = L-1;
      end
      if (a > STEP/2 + (L-1)*STEP) nclip++;
`ifdef PAM_GRAY_EN
      lvl = lvl ^ (lvl >> 1);
`endif
      ey[(p-1)*B +: B] = B'(lvl);
    end
  endfunction

  // Scoreboard, sampled mid-cycle where handshakes are stable.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cum = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stale_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("y", y, e.y);
          check("out_last", out_last, e.last);
          check("clip_cnt", clip_cnt, e.clip);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int nc;
        model(u, e.y, nc);
        cum = cum + nc;
        if (cum > 16'hFFFF) cum = 16'hFFFF;
        e.last = in_last;
        e.clip = 16'(cum);
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [N*W-1:0] pack(input int s[N]);
    logic [N*W-1:0] w;
    for (int k = 0; k < N; k++) w[k*W +: W] = W'(s[k]);
    return w;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [N*W-1:0] w, input logic l);
    bit acc;
    int t;
    t = 0;
    in_valid = 1; u = w; in_last = l;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 1000);
    if (!acc) check("push_timeout", 0, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rand_rdy = 0; out_ready = 1;
    while ((q.size() != 0 || out_valid) && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) check("drain_timeout", 0, 1);
  endtask

  int s[N];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_y", y, 0);
    check("rst_clip", clip_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed words on channel 15 and channel 0.
    foreach (s[k]) s[k] = 0;
    push_word(pack(s), 0);
    s[15] = 17;  push_word(pack(s), 0);
    s[15] = 100; push_word(pack(s), 0);
    s[15] = -50; s[0] = 2000; push_word(pack(s), 0);
    for (int v = 0; v < 4; v++) begin
      s[15] = v*STEP; s[0] = 0; push_word(pack(s), v == 3);
    end
    drain();
    check("dir_clip_total", clip_cnt, 1);

    // Latency: empty pipe, out_ready high.
    s[15] = 30; push_word(pack(s), 1);
    @(negedge clk); check("lat_t1", out_valid, 0);
    @(negedge clk); check("lat_t2", out_valid, 1);
    drain();

    // Back-to-back 4 words with out_ready low in cycles 2-4.
    fork
      for (int i = 0; i < 4; i++) begin
        foreach (s[k]) s[k] = $urandom_range(0, 220) - 100;
        push_word(pack(s), i == 3);
      end
      begin
        out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk); #1;
        @(posedge clk); #1 out_ready = 1;
      end
    join
    drain();

    // Random traffic with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      foreach (s[k]) s[k] = $urandom_range(0, 220) - 100;
      s[0] = $urandom_range(0, 4095);
      push_word(pack(s), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // Reset with two words in flight.
    out_ready = 0;
    foreach (s[k]) s[k] = 100;
    push_word(pack(s), 0);
    push_word(pack(s), 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_clip", clip_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (5) begin @(negedge clk); check("midrst_no_stale", out_valid, 0); end
    @(posedge clk); #1;

    // Saturation: every channel clips.
    foreach (s[k]) s[k] = 100;
    for (int i = 0; i < 4400; i++) push_word(pack(s), i == 4399);
    drain();
    check("sat_clip", clip_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
